// File: rtl/fx3_stream_in_ctrl.sv
// FX3 slave-FIFO stream-in controller.
// Moves upstream words into the FX3 FIFO in buffers of BURST_LEN words.
// A full buffer is auto-committed by FX3. A short buffer is committed
// with a one-cycle pktend_ pulse, either on flush or when enable drops.
// Every commit is followed by GAP_CYC idle cycles so the FX3 flags can settle.
//
// Upstream handshake: a word moves only in a cycle where s_valid and s_ready
// are both high. s_ready is combinational and never depends on s_valid.
// The source must hold s_data stable while s_valid is high and s_ready is low.
module fx3_stream_in_ctrl #(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 1024,
   parameter int GAP_CYC   = 4,
   parameter int ZLP_EN    = 0
) (
   input  logic                           clk_100,
   input  logic                           reset_,
   input  logic                           enable,
   input  logic                           flaga_d,
   input  logic                           flagb_d,
   input  logic [DATA_W-1:0]              s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           flush,
   output logic                           slwr_,
   output logic                           pktend_,
   output logic [DATA_W-1:0]              fifo_data,
   output logic                           busy,
   output logic [$clog2(BURST_LEN+1)-1:0] word_cnt,
   output logic [15:0]                    pkt_count,
   output logic [2:0]                     state_dbg
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(BURST_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FLAGB = 3'd1,
      WRITE      = 3'd2,
      PKTEND     = 3'd3,
      GAP        = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            accept;
   logic            gap_enter;
   logic [CW-1:0]   cnt_inc;
   logic [GW-1:0]   gap_cnt;

   assign s_ready   = (state == WRITE) && enable && flagb_d && (word_cnt < CNT_FULL);
   assign accept    = s_valid && s_ready;
   // Buffer fill including a word accepted this cycle.
   assign cnt_inc   = word_cnt + CW'(accept);
   assign gap_enter = (state_nx == GAP) && (state != GAP);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; a full buffer wins over enable loss, which wins over flush.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (enable && flaga_d) state_nx = WAIT_FLAGB;
         end
         WAIT_FLAGB: begin
            if (!enable)      state_nx = (word_cnt != '0) ? PKTEND : IDLE;
            else if (flagb_d) state_nx = WRITE;
         end
         WRITE: begin
            if (accept && (cnt_inc == CNT_FULL))
               state_nx = GAP;
            else if (!enable)
               state_nx = (cnt_inc != '0) ? PKTEND : IDLE;
            else if (flush && ((cnt_inc != '0) || (ZLP_EN != 0)))
               state_nx = PKTEND;
            else if (!flagb_d)
               state_nx = WAIT_FLAGB;
         end
         PKTEND: begin
            state_nx = GAP;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // FIFO-side strobes and data: one registered write per accepted word,
   // pktend_ in the cycle after PKTEND so it trails any last write.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         slwr_     <= 1'b1;
         pktend_   <= 1'b1;
         fifo_data <= '0;
      end else begin
         slwr_   <= !accept;
         pktend_ <= (state != PKTEND);
         if (accept) fifo_data <= s_data;
      end
   end

   // Buffer fill count, committed-packet count and gap timer.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         word_cnt  <= '0;
         pkt_count <= '0;
         gap_cnt   <= '0;
      end else begin
         if (gap_enter)   word_cnt <= '0;
         else if (accept) word_cnt <= cnt_inc;
         if (gap_enter) pkt_count <= pkt_count + 16'd1;
         if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
         else              gap_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_fx3_stream_in_ctrl.sv
// Bench for fx3_stream_in_ctrl with BURST_LEN=4, GAP_CYC=2.
// Two instances share every input: one without and one with zero-length
// packets enabled. A behavioural reference model per instance predicts all
// outputs each cycle; a queue checks the written data stream of instance 0.
module tb_fx3_stream_in_ctrl;

   localparam int DW = 32;
   localparam int BL = 4;
   localparam int GC = 2;
   localparam int CW = $clog2(BL + 1);

   localparam int PH_IDLE   = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_WRITE  = 2;
   localparam int PH_COMMIT = 3;
   localparam int PH_GAP    = 4;

   // ---------------- clock / reset ----------------
   logic clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   logic          reset_  = 1'b0;
   logic          enable  = 1'b0;
   logic          flaga_d = 1'b1;
   logic          flagb_d = 1'b1;
   logic [DW-1:0] s_data  = '0;
   logic          s_valid = 1'b0;
   logic          flush   = 1'b0;

   logic [1:0]    rdy_o;
   logic [1:0]    slwr_o;
   logic [1:0]    pktend_o;
   logic [1:0]    busy_o;
   logic [DW-1:0] fd_o [2];
   logic [CW-1:0] wc_o [2];
   logic [15:0]   pc_o [2];
   logic [2:0]    st_o [2];

   fx3_stream_in_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .GAP_CYC(GC), .ZLP_EN(0)) dut (
      .clk_100(clk_100), .reset_(reset_), .enable(enable), .flaga_d(flaga_d),
      .flagb_d(flagb_d), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_o[0]),
      .flush(flush), .slwr_(slwr_o[0]), .pktend_(pktend_o[0]), .fifo_data(fd_o[0]),
      .busy(busy_o[0]), .word_cnt(wc_o[0]), .pkt_count(pc_o[0]), .state_dbg(st_o[0])
   );

   fx3_stream_in_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .GAP_CYC(GC), .ZLP_EN(1)) dut_z (
      .clk_100(clk_100), .reset_(reset_), .enable(enable), .flaga_d(flaga_d),
      .flagb_d(flagb_d), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_o[1]),
      .flush(flush), .slwr_(slwr_o[1]), .pktend_(pktend_o[1]), .fifo_data(fd_o[1]),
      .busy(busy_o[1]), .word_cnt(wc_o[1]), .pkt_count(pc_o[1]), .state_dbg(st_o[1])
   );

   // ---------------- scoreboard state ----------------
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];
   int            cyc = 0;
   int            wr_seen [2];
   int            pk_seen [2];
   int            first_wr = -1;
   int            last_wr = -1;
   logic [DW-1:0] next_d = 32'd1;

   // ---------------- reference model ----------------
   int            m_ph     [2];
   int            m_cnt    [2];
   int            m_gap    [2];
   int            m_pkts   [2];
   bit            m_slwr   [2];
   bit            m_pktend [2];
   logic [DW-1:0] m_data   [2];
   bit            m_acc    [2];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void model_reset(input int i);
      m_ph[i] = PH_IDLE; m_cnt[i] = 0; m_gap[i] = 0; m_pkts[i] = 0;
      m_slwr[i] = 1'b1; m_pktend[i] = 1'b1; m_data[i] = '0; m_acc[i] = 1'b0;
   endfunction

   function automatic bit model_ready(input int i);
      return (m_ph[i] == PH_WRITE) && enable && flagb_d && (m_cnt[i] < BL);
   endfunction

   // Buffer committed: fill resets, packet counted, quiet period begins.
   function automatic void model_commit(input int i);
      m_ph[i] = PH_GAP; m_cnt[i] = 0; m_gap[i] = GC;
      m_pkts[i] = (m_pkts[i] + 1) % 65536;
   endfunction

   // Advance one clock edge with the inputs currently driven.
   function automatic void model_step(input int i, input bit zlp);
      bit acc;
      int n;
      acc = model_ready(i) && s_valid;
      m_acc[i] = acc;
      m_slwr[i] = !acc;
      if (acc) m_data[i] = s_data;
      if (acc && i == 0) exp_q.push_back(s_data);
      m_pktend[i] = (m_ph[i] != PH_COMMIT);
      n = m_cnt[i] + int'(acc);
      case (m_ph[i])
         PH_IDLE: if (enable && flaga_d) m_ph[i] = PH_WAIT;
         PH_WAIT: begin
            if (!enable)      m_ph[i] = (m_cnt[i] > 0) ? PH_COMMIT : PH_IDLE;
            else if (flagb_d) m_ph[i] = PH_WRITE;
         end
         PH_WRITE: begin
            m_cnt[i] = n;
            if (n == BL)                       model_commit(i);
            else if (!enable)                  m_ph[i] = (n > 0) ? PH_COMMIT : PH_IDLE;
            else if (flush && (n > 0 || zlp)) m_ph[i] = PH_COMMIT;
            else if (!flagb_d)                 m_ph[i] = PH_WAIT;
         end
         PH_COMMIT: model_commit(i);
         default: begin
            m_gap[i]--;
            if (m_gap[i] == 0) m_ph[i] = PH_IDLE;
         end
      endcase
   endfunction

   task automatic check_inst(input int i);
      check_eq($sformatf("s_ready[%0d]", i),   rdy_o[i],    model_ready(i));
      check_eq($sformatf("slwr_[%0d]", i),     slwr_o[i],   m_slwr[i]);
      check_eq($sformatf("pktend_[%0d]", i),   pktend_o[i], m_pktend[i]);
      check_eq($sformatf("fifo_data[%0d]", i), fd_o[i],     m_data[i]);
      check_eq($sformatf("busy[%0d]", i),      busy_o[i],   m_ph[i] != PH_IDLE);
      check_eq($sformatf("word_cnt[%0d]", i),  wc_o[i],     m_cnt[i]);
      check_eq($sformatf("pkt_count[%0d]", i), pc_o[i],     m_pkts[i]);
      check_eq($sformatf("excl[%0d]", i),      slwr_o[i] | pktend_o[i], 1);
      if (slwr_o[i] == 1'b0) wr_seen[i]++;
      if (pktend_o[i] == 1'b0) pk_seen[i]++;
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      #1;
      if (!reset_) begin
         model_reset(0); model_reset(1); exp_q.delete();
      end
      check_inst(0);
      check_inst(1);
      if (slwr_o[0] == 1'b0) begin
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (exp_q.size() == 0) check_eq("sb_unexpected_write", 1, 0);
         else                   check_eq("sb_data", fd_o[0], exp_q.pop_front());
      end
      if (reset_) begin
         model_step(0, 1'b0);
         model_step(1, 1'b1);
      end
      cyc++;
      @(negedge clk_100);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Offer incrementing words until n are accepted (bounded).
   task automatic feed(input int n);
      int got;
      got = 0;
      s_valid = 1'b1;
      for (int c = 0; c < 40 && got < n; c++) begin
         s_data = next_d;
         tick();
         if (m_acc[0]) begin
            got++;
            next_d = next_d + 1;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic clear_counts();
      wr_seen[0] = 0; wr_seen[1] = 0; pk_seen[0] = 0; pk_seen[1] = 0;
      first_wr = -1; last_wr = -1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int p0;
      model_reset(0);
      model_reset(1);
      clear_counts();
      @(negedge clk_100);
      tick();
      check_eq("rst_slwr", slwr_o[0], 1);
      check_eq("rst_pktend", pktend_o[0], 1);
      check_eq("rst_data", fd_o[0], 0);
      check_eq("rst_ready", rdy_o[0], 0);
      reset_ = 1'b1;
      run(2);

      // Full buffer of 1..4 under continuous valid.
      clear_counts();
      enable = 1'b1;
      feed(4);
      enable = 1'b0;
      run(3);
      check_eq("full_writes", wr_seen[0], 4);
      check_eq("full_consecutive", last_wr - first_wr, 3);
      check_eq("full_pkts", pc_o[0], 1);
      check_eq("full_idle", busy_o[0], 0);

      // Two words then flush.
      clear_counts();
      p0 = int'(pc_o[0]);
      enable = 1'b1;
      feed(2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      enable = 1'b0;
      tick();
      check_eq("flush_pktend", pktend_o[0], 0);
      check_eq("flush_cnt", wc_o[0], 0);
      check_eq("flush_pkts", pc_o[0], p0 + 1);
      run(3);
      check_eq("flush_writes", wr_seen[0], 2);
      check_eq("flush_pulses", pk_seen[0], 1);

      // Flush on an empty buffer: ignored vs zero-length packet.
      clear_counts();
      enable = 1'b1;
      run(2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      enable = 1'b0;
      run(5);
      check_eq("zlp_off_pulses", pk_seen[0], 0);
      check_eq("zlp_on_pulses", pk_seen[1], 1);
      check_eq("zlp_on_writes", wr_seen[1], 0);

      // flagb_d drop after two words, then resume.
      clear_counts();
      enable = 1'b1;
      feed(2);
      flagb_d = 1'b0;
      s_valid = 1'b1;
      s_data = next_d;
      tick();
      check_eq("flagb_ready", rdy_o[0], 0);
      check_eq("flagb_hold", wc_o[0], 2);
      run(2);
      check_eq("flagb_hold_late", wc_o[0], 2);
      flagb_d = 1'b1;
      feed(2);
      enable = 1'b0;
      run(4);
      check_eq("flagb_writes", wr_seen[0], 4);
      check_eq("flagb_no_pulse", pk_seen[0], 0);

      // enable drop after three words.
      clear_counts();
      enable = 1'b1;
      feed(3);
      enable = 1'b0;
      run(2);
      check_eq("en_pktend", pktend_o[0], 0);
      run(3);
      check_eq("en_idle", busy_o[0], 0);
      check_eq("en_pulses", pk_seen[0], 1);
      check_eq("en_writes", wr_seen[0], 3);

      // Reset after one word.
      clear_counts();
      enable = 1'b1;
      feed(1);
      reset_ = 1'b0;
      tick();
      check_eq("mid_rst_slwr", slwr_o[0], 1);
      check_eq("mid_rst_cnt", wc_o[0], 0);
      check_eq("mid_rst_pkts", pc_o[0], 0);
      check_eq("mid_rst_busy", busy_o[0], 0);
      reset_ = 1'b1;
      enable = 1'b0;
      run(5);
      check_eq("mid_rst_no_pulse", pk_seen[0], 0);

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         enable  = ($urandom_range(0, 19) != 0);
         flaga_d = ($urandom_range(0, 3) != 0);
         flagb_d = ($urandom_range(0, 4) != 0);
         s_valid = $urandom_range(0, 1);
         s_data  = $urandom;
         flush   = ($urandom_range(0, 9) == 0);
         reset_  = ($urandom_range(0, 299) != 0);
         tick();
      end
      reset_ = 1'b1;
      enable = 1'b0;
      flush = 1'b0;
      s_valid = 1'b0;
      run(10);
      check_eq("sb_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fx3_stream_in_ctrl.md
FX3_STREAM_IN_CTRL -- requirements
Module: fx3_stream_in_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the FIFO data bus.
REQ-002 SHALL have parameter BURST_LEN, default 1024, words per full FX3 buffer (>=2).
REQ-003 SHALL have parameter GAP_CYC, default 4, idle cycles after each buffer commit (>=1).
REQ-004 SHALL have parameter ZLP_EN, default 0, which allows flush with an empty buffer to emit a zero-length packet when 1.
REQ-005 SHALL have port clk_100 in 1, the 100 MHz clock, all logic on its rising edge.
REQ-006 SHALL have port reset_ in 1, an asynchronous, active-low reset.
REQ-007 SHALL have port enable in 1, which selects stream-in mode.
REQ-008 SHALL have port flaga_d in 1, the synchronised FX3 not-full flag, high meaning space available.
REQ-009 SHALL have port flagb_d in 1, the synchronised FX3 watermark flag, high meaning above the watermark.
REQ-010 SHALL have port s_data in DATA_W, the upstream word.
REQ-011 SHALL have port s_valid in 1, the upstream word valid.
REQ-012 SHALL have port s_ready out 1, which accepts the upstream word.
REQ-013 SHALL have port flush in 1, a single-cycle request to commit a short packet.
REQ-014 SHALL have port slwr_ out 1, the FX3 write strobe, active-low.
REQ-015 SHALL have port pktend_ out 1, the FX3 packet end, active-low.
REQ-016 SHALL have port fifo_data out DATA_W, the FX3 data bus.
REQ-017 SHALL have port busy out 1, high in any state except IDLE.
REQ-018 SHALL have port word_cnt out $clog2(BURST_LEN+1), the words written into the current buffer.
REQ-019 SHALL have port pkt_count out 16, the count of committed packets, which wraps from 0xFFFF to 0.

Function
REQ-020 SHALL implement the states IDLE, WAIT_FLAGB, WRITE, PKTEND and GAP.
REQ-021 SHALL move IDLE->WAIT_FLAGB when enable && flaga_d.
REQ-022 SHALL move WAIT_FLAGB->WRITE when flagb_d.
REQ-023 SHALL move WAIT_FLAGB->IDLE when !enable && word_cnt==0.
REQ-024 SHALL move WAIT_FLAGB->PKTEND when !enable && word_cnt>0.
REQ-025 SHALL drive s_ready = (state==WRITE) && enable && flagb_d && (word_cnt<BURST_LEN), combinationally.
REQ-026 SHALL treat a cycle with s_valid && s_ready as an accept.
REQ-027 SHALL, on an accept, register s_data into fifo_data and register slwr_=0 for the next cycle only.
REQ-028 SHALL give each accepted word exactly one write, with a latency of 1 cycle from accept to slwr_ low.
REQ-029 SHALL hold fifo_data at its last value when no word is accepted.
REQ-030 SHALL increment word_cnt by 1 per accept.
REQ-031 SHALL, on an accept that makes word_cnt reach BURST_LEN, move WRITE->GAP, since FX3 auto-commits the full buffer.
REQ-032 SHALL, on a flush in WRITE with word_cnt>0, or with an accept in that same cycle, move to PKTEND, with the simultaneous word written before pktend_.
REQ-033 SHALL, on a flush in WRITE with word_cnt==0 and no accept, move to PKTEND when ZLP_EN=1 and ignore the flush when ZLP_EN=0.
REQ-034 SHALL ignore a flush in any state except WRITE.
REQ-035 SHALL, on flagb_d low in WRITE (with no full-buffer or flush exit), move to WAIT_FLAGB and keep word_cnt.
REQ-036 SHALL, on enable low in WRITE, move to PKTEND if word_cnt (including any same-cycle accept) >0, else to IDLE.
REQ-037 SHALL, in PKTEND, register pktend_=0 for exactly one cycle with slwr_=1, then move to GAP.
REQ-038 SHALL clear word_cnt and increment pkt_count on entry to GAP.
REQ-039 SHALL hold GAP for GAP_CYC cycles with s_ready=0, then move to IDLE.
REQ-040 SHALL NOT assert slwr_ and pktend_ low in the same cycle.

Reset
REQ-041 SHALL, on reset_ low, immediately force state=IDLE, slwr_=1, pktend_=1, fifo_data=0, word_cnt=0, pkt_count=0 and s_ready=0.
REQ-042 SHALL, when reset_ is asserted mid-burst, discard the partial buffer with no pktend_ pulse.

Verification (BURST_LEN=4, GAP_CYC=2)
REQ-043 SHALL verify that with enable=1, flags high and s_valid held with data 1..4, there are 4 consecutive slwr_ lows carrying 1..4, one cycle after each accept, then 2 GAP cycles and pkt_count=1.
REQ-044 SHALL verify that writing 2 words then pulsing flush gives 2 writes, pktend_ low for 1 cycle after the second write, word_cnt=0 and pkt_count+1.
REQ-045 SHALL verify that flush with word_cnt=0 gives no pktend_ when ZLP_EN=0 and a single pktend_ pulse with no slwr_ when ZLP_EN=1.
REQ-046 SHALL verify that flagb_d dropping after 2 words gives s_ready=0 next cycle with word_cnt holding at 2, and flagb_d returning resumes with the 3rd word.
REQ-047 SHALL verify that enable dropping after 3 words causes a pktend_ pulse, then GAP, then IDLE.
REQ-048 SHALL verify that reset_ asserted after 1 word immediately gives outputs at their reset values with no pktend_ pulse.
